qe_bus_sequencer: RTL

//  Clocked, parametrised successor to the QL expansion-bus decoder. Sits between the 68008 bus
//  (asl/dsl/rdwl/address) and the W5300 plus the 7-segment latch. Synchronises the asynchronous

---
 rtl/qe_bus_pkg.sv | 65 ++++++
 rtl/qe_sync.sv | 23 ++
 rtl/qe_bus_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/qe_bus_pkg.sv
// Shared definitions for the QL expansion-bus sequencer: FSM state codes,
// decoded region, the registered output bundle and its decode function.
package qe_bus_pkg;

   localparam int              DEF_ADDR_W      = 12;
   localparam logic [11:0]     DEF_WIZ_BASE    = 12'h180;
   localparam int              DEF_WIZ_SZ_LOG2 = 4;
   localparam logic [11:0]     DEF_SEG_BASE    = 12'h190;
   localparam int              DEF_SEG_SZ_LOG2 = 4;

   // FSM state codes, kept as plain constants for compatibility with older tools.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_ACK    = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;

   typedef enum logic [1:0] {
      REG_NONE = 2'd0,
      REG_WIZ  = 2'd1,
      REG_SEG  = 2'd2
   } region_t;

   typedef struct packed {
      logic dtackl;
      logic dsmcl;
      logic gate7seg;
      logic dbenl;
      logic dbdir;
      logic wizcsl;
      logic wizrdl;
      logic wizwrl;
   } bus_out_t;

   localparam bus_out_t OUT_IDLE = '{dtackl: 1'b1, dsmcl: 1'b1, gate7seg: 1'b0,
                                     dbenl: 1'b1, dbdir: 1'b0, wizcsl: 1'b1,
                                     wizrdl: 1'b1, wizwrl: 1'b1};

   // Output levels for a given state, latched region and latched direction.
   function automatic bus_out_t drive_outputs(input logic [2:0] st, input region_t rg,
                                              input logic rd);
      bus_out_t o;
      logic     busy;
      logic     strobing;
      logic     wiz;
      o        = OUT_IDLE;
      busy     = (st != ST_IDLE);
      strobing = (st == ST_STROBE) || (st == ST_ACK);
      wiz      = (rg == REG_WIZ);
      if (busy) begin
         o.dsmcl  = 1'b0;
         o.dbenl  = 1'b0;
         o.dbdir  = rd;
         o.wizcsl = !wiz;
      end
      if (strobing) begin
         o.wizrdl   = !(wiz && rd);
         o.wizwrl   = !(wiz && !rd);
         o.gate7seg = (rg == REG_SEG);
      end
      o.dtackl = (st != ST_ACK);
      return o;
   endfunction

endpackage

// File: rtl/qe_sync.sv
// Multi-flop synchroniser for an asynchronous active-low bus strobe.
// Resets to 1 so a strobe never appears asserted straight out of reset.
module qe_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetl,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (!resetl) ff <= '1;
      else         ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/qe_bus_sequencer.sv
// Clocked 68008 expansion-bus sequencer: synchronises the bus strobes,
// decodes the W5300 and 7-segment windows, and runs the cs/rd/wr timing
// with programmable setup/strobe/hold before returning dtackl.
module qe_bus_sequencer
   import qe_bus_pkg::*;
#(
   parameter int                ADDR_W      = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] WIZ_BASE    = DEF_WIZ_BASE,
   parameter int                WIZ_SZ_LOG2 = DEF_WIZ_SZ_LOG2,
   parameter logic [ADDR_W-1:0] SEG_BASE    = DEF_SEG_BASE,
   parameter int                SEG_SZ_LOG2 = DEF_SEG_SZ_LOG2,
   parameter int                SETUP_CYC   = 1,
   parameter int                STROBE_CYC  = 3,
   parameter int                HOLD_CYC    = 1,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              resetl,
   input  logic [ADDR_W-1:0] address,
   input  logic              asl,
   input  logic              dsl,
   input  logic              rdwl,
   output logic              dtackl,
   output logic              dsmcl,
   output logic              gate7seg,
   output logic              dbenl,
   output logic              dbdir,
   output logic              wizcsl,
   output logic              wizrdl,
   output logic              wizwrl
);

   localparam logic [ADDR_W-1:0] WIZ_MASK  = ~((ADDR_W'(1) << WIZ_SZ_LOG2) - ADDR_W'(1));
   localparam logic [ADDR_W-1:0] SEG_MASK  = ~((ADDR_W'(1) << SEG_SZ_LOG2) - ADDR_W'(1));
   localparam logic [3:0]        SETUP_LD  = (SETUP_CYC  > 0) ? 4'(SETUP_CYC - 1)  : 4'd0;
   localparam logic [3:0]        STROBE_LD = (STROBE_CYC > 0) ? 4'(STROBE_CYC - 1) : 4'd0;
   localparam logic [3:0]        HOLD_LD   = (HOLD_CYC   > 0) ? 4'(HOLD_CYC - 1)   : 4'd0;
   localparam logic [1:0]        SETTLE_N  = 2'(SYNC_STAGES);

   logic       as_s, ds_s, rw_s;
   logic       hit_wiz, hit_seg, start;
   logic [2:0] state, state_nxt;
   region_t    region, region_nxt;
   logic       rw, rw_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       armed;
   logic [1:0] settle;
   bus_out_t   out_q, out_nxt;

   qe_sync #(.STAGES(SYNC_STAGES)) u_sync_as (.clk(clk), .resetl(resetl), .d(asl),  .q(as_s));
   qe_sync #(.STAGES(SYNC_STAGES)) u_sync_ds (.clk(clk), .resetl(resetl), .d(dsl),  .q(ds_s));
   qe_sync #(.STAGES(SYNC_STAGES)) u_sync_rw (.clk(clk), .resetl(resetl), .d(rdwl), .q(rw_s));

   assign hit_wiz = (address & WIZ_MASK) == (WIZ_BASE & WIZ_MASK);
   assign hit_seg = ((address & SEG_MASK) == (SEG_BASE & SEG_MASK)) && !rw_s;
   assign start   = armed && !as_s && !ds_s && (hit_wiz || hit_seg);

   // Next-state, region/direction latch and phase counter.
   always_comb begin
      logic go_hold;
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_nxt  = state;
      region_nxt = region;
      rw_nxt     = rw;
      cnt_nxt    = cnt;
      go_hold    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               region_nxt = hit_wiz ? REG_WIZ : REG_SEG;
               rw_nxt     = rw_s;
               if (SETUP_CYC == 0) begin
                  state_nxt = ST_STROBE;
                  cnt_nxt   = STROBE_LD;
               end else begin
                  state_nxt = ST_SETUP;
                  cnt_nxt   = SETUP_LD;
               end
            end
         end
         ST_SETUP: begin
            if (as_s) go_hold = 1'b1;
            else if (cnt == 4'd0) begin
               state_nxt = ST_STROBE;
               cnt_nxt   = STROBE_LD;
            end else cnt_nxt = cnt - 4'd1;
         end
         ST_STROBE: begin
            if (as_s) go_hold = 1'b1;
            else if (cnt == 4'd0) begin
               state_nxt = ST_ACK;
               cnt_nxt   = 4'd0;
            end else cnt_nxt = cnt - 4'd1;
         end
         ST_ACK: begin
            if (as_s || ds_s) go_hold = 1'b1;
         end
         ST_HOLD: begin
            if (cnt == 4'd0) begin
               state_nxt  = ST_IDLE;
               region_nxt = REG_NONE;
            end else cnt_nxt = cnt - 4'd1;
         end
         default: begin
            state_nxt  = ST_IDLE;
            region_nxt = REG_NONE;
            cnt_nxt    = 4'd0;
         end
      endcase
      if (go_hold) begin
         if (HOLD_CYC == 0) begin
            state_nxt  = ST_IDLE;
            region_nxt = REG_NONE;
            cnt_nxt    = 4'd0;
         end else begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LD;
         end
      end
      out_nxt = drive_outputs(state_nxt, region_nxt, rw_nxt);
   end

   // State, counter, re-arm tracking and registered outputs.
   always_ff @(posedge clk) begin
      if (!resetl) begin
         state  <= ST_IDLE;
         region <= REG_NONE;
         rw     <= 1'b0;
         cnt    <= 4'd0;
         armed  <= 1'b0;
         settle <= 2'd0;
         out_q  <= OUT_IDLE;
      end else begin
         state  <= state_nxt;
         region <= region_nxt;
         rw     <= rw_nxt;
         cnt    <= cnt_nxt;
         out_q  <= out_nxt;
         // Ignore as_s until the synchronisers have flushed their reset value,
         // so a strobe held through reset cannot re-trigger.
         if (settle != SETTLE_N) settle <= settle + 2'd1;
         if (start)                               armed <= 1'b0;
         else if (as_s && (settle == SETTLE_N))   armed <= 1'b1;
      end
   end

   assign dtackl   = out_q.dtackl;
   assign dsmcl    = out_q.dsmcl;
   assign gate7seg = out_q.gate7seg;
   assign dbenl    = out_q.dbenl;
   assign dbdir    = out_q.dbdir;
   assign wizcsl   = out_q.wizcsl;
   assign wizrdl   = out_q.wizrdl;
   assign wizwrl   = out_q.wizwrl;

endmodule
